// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared state encoding and byte-lane constants for the boot image loader
package prog_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLUSH,
    RELEASE,
    RUN,
    HALT
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);
  localparam int DEFAULT_RST_HOLD = 4;

endpackage

// File: rtl/prog_loader_byte_packer.sv
// rtl/prog_loader_byte_packer.sv - little-endian byte-to-word packer with zero-padded flush
module prog_loader_byte_packer
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        accept,
  input  logic [7:0]  in_data,
  input  logic        flush,
  output logic        word_valid,
  output logic [31:0] word_data,
  output logic [1:0]  byte_idx
);

  // lanes only ever holds bytes of the current word; unfilled lanes stay zero
  logic [23:0] lanes;

  always_comb begin
    word_valid = flush || (accept && byte_idx == LAST_LANE);
    word_data  = flush ? {8'h00, lanes} : {in_data, lanes};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_idx <= 2'd0;
      lanes    <= 24'd0;
    end else if (flush || (accept && byte_idx == LAST_LANE)) begin
      byte_idx <= 2'd0;
      lanes    <= 24'd0;
    end else if (accept) begin
      case (byte_idx)
        2'd0:    lanes[7:0]   <= in_data;
        2'd1:    lanes[15:8]  <= in_data;
        2'd2:    lanes[23:16] <= in_data;
        default: ;
      endcase
      byte_idx <= byte_idx + 2'd1;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - boot image loader: writes a byte-streamed image to IM/DM, then releases core reset
// Optional LOADER_CHECKSUM_EN adds exp_sum, chk_sum and err_checksum.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int MEM_WORDS = 100,
  parameter int ADDR_W    = 32,
  parameter int RST_HOLD  = DEFAULT_RST_HOLD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              err_overflow,
`ifdef LOADER_CHECKSUM_EN
  input  logic [31:0]       exp_sum,
  output logic [31:0]       chk_sum,
  output logic              err_checksum,
`endif
  output logic [ADDR_W-1:0] word_count
);

  state_t      state;
  state_t      fin_state;
  logic [7:0]  hold_cnt;
  logic        accept;
  logic        flush;
  logic        full;
  logic        word_valid;
  logic [31:0] word_data;
  logic [1:0]  byte_idx;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] exp_q;
  logic [31:0] sum_next;
  logic        chk_bad;
`endif

  assign accept = in_valid && in_ready;
  assign flush  = (state == FLUSH);
  assign full   = (word_count == ADDR_W'(MEM_WORDS));

  prog_loader_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .accept     (accept),
    .in_data    (in_data),
    .flush      (flush),
    .word_valid (word_valid),
    .word_data  (word_data),
    .byte_idx   (byte_idx)
  );

  // Where the image ends up once its final word has been handled
  always_comb begin
    fin_state = RELEASE;
`ifdef LOADER_CHECKSUM_EN
    sum_next = chk_sum + word_data;
    chk_bad  = !(err_overflow || full) && (sum_next != exp_q);
    if (err_overflow || full || chk_bad) fin_state = HALT;
`else
    if (err_overflow || full) fin_state = HALT;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      in_ready     <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= 32'd0;
      core_rst     <= 1'b1;
      done         <= 1'b0;
      err_overflow <= 1'b0;
      word_count   <= '0;
      hold_cnt     <= 8'd0;
`ifdef LOADER_CHECKSUM_EN
      exp_q        <= 32'd0;
      chk_sum      <= 32'd0;
      err_checksum <= 1'b0;
`endif
    end else begin
      mem_we <= 1'b0;
      if (word_valid) begin
        if (full) begin
          err_overflow <= 1'b1;
        end else begin
          mem_we     <= 1'b1;
          mem_addr   <= word_count;
          mem_wdata  <= word_data;
          word_count <= word_count + ADDR_W'(1);
`ifdef LOADER_CHECKSUM_EN
          chk_sum    <= sum_next;
`endif
        end
      end

      case (state)
        IDLE: begin
          state    <= LOAD;
          in_ready <= 1'b1;
        end
        LOAD: begin
`ifdef LOADER_CHECKSUM_EN
          exp_q <= exp_sum;
`endif
          if (accept && in_last) begin
            in_ready <= 1'b0;
            hold_cnt <= 8'd0;
            if (byte_idx != LAST_LANE) begin
              state <= FLUSH;
            end else begin
              state <= fin_state;
`ifdef LOADER_CHECKSUM_EN
              if (chk_bad) err_checksum <= 1'b1;
`endif
            end
          end
        end
        FLUSH: begin
          state <= fin_state;
`ifdef LOADER_CHECKSUM_EN
          if (chk_bad) err_checksum <= 1'b1;
`endif
        end
        RELEASE: begin
          if (hold_cnt == 8'(RST_HOLD - 1)) begin
            state    <= RUN;
            core_rst <= 1'b0;
            done     <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        RUN, HALT: ;
        default: state <= HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed vector-table bench for prog_loader (MEM_WORDS=2, RST_HOLD=4)
module tb_prog_loader;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        core_rst;
  logic        done;
  logic        err_overflow;
  logic [31:0] word_count;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] exp_sum;
  logic [31:0] chk_sum;
  logic        err_checksum;
`endif

  int nchk;
  int nerr;
  logic [31:0] wa[$];
  logic [31:0] wd[$];

  prog_loader #(.MEM_WORDS(2), .ADDR_W(32), .RST_HOLD(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .core_rst     (core_rst),
    .done         (done),
    .err_overflow (err_overflow),
`ifdef LOADER_CHECKSUM_EN
    .exp_sum      (exp_sum),
    .chk_sum      (chk_sum),
    .err_checksum (err_checksum),
`endif
    .word_count   (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst && mem_we) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
    end
  end

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        l;
    logic        rdy;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        crst;
    logic        dn;
    logic [7:0]  wc;
  } vec_t;

  vec_t tbl[15];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_data = 8'h00;
    repeat (2) @(negedge clk);
    wa.delete();
    wd.delete();
    rst = 1'b1;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    int t;
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      nchk++;
      nerr++;
      $display("FAIL send_timeout: in_ready got 0 expected 1 for byte 0x%02h", d);
    end
    in_valid = 1'b1;
    in_data = d;
    in_last = l;
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_done(output int k);
    k = 0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic check_write(input int i, input logic [31:0] a, input logic [31:0] d);
    if (wa.size() > i) begin
      check($sformatf("w%0d_addr", i), wa[i], a);
      check($sformatf("w%0d_data", i), wd[i], d);
    end else begin
      check($sformatf("w%0d_missing", i), 32'(wa.size()), 32'(i + 1));
    end
  endtask

  initial begin
    int k;
    nchk = 0;
    nerr = 0;
`ifdef LOADER_CHECKSUM_EN
    exp_sum = 32'h0;
`endif
    //            v     d      l     rdy   we    addr   wdata          crst  dn    wc
    tbl[0]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0,         1'b1, 1'b0, 8'd0};
    tbl[1]  = '{1'b1, 8'h13, 1'b0, 1'b1, 1'b0, 32'd0, 32'h0,         1'b1, 1'b0, 8'd0};
    tbl[2]  = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 32'd0, 32'h0,         1'b1, 1'b0, 8'd0};
    tbl[3]  = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 32'd0, 32'h0,         1'b1, 1'b0, 8'd0};
    tbl[4]  = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 32'd0, 32'h0,         1'b1, 1'b0, 8'd0};
    tbl[5]  = '{1'b1, 8'h93, 1'b0, 1'b1, 1'b1, 32'd0, 32'h00000013,  1'b1, 1'b0, 8'd1};
    tbl[6]  = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 32'd0, 32'h0,         1'b1, 1'b0, 8'd1};
    tbl[7]  = '{1'b1, 8'h10, 1'b0, 1'b1, 1'b0, 32'd0, 32'h0,         1'b1, 1'b0, 8'd1};
    tbl[8]  = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 32'd0, 32'h0,         1'b1, 1'b0, 8'd1};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 32'd1, 32'h00100093,  1'b1, 1'b0, 8'd2};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0,         1'b1, 1'b0, 8'd2};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0,         1'b1, 1'b0, 8'd2};
    tbl[12] = '{1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 32'd0, 32'h0,         1'b1, 1'b0, 8'd2};
    tbl[13] = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0,         1'b0, 1'b1, 8'd2};
    tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0,         1'b0, 1'b1, 8'd2};

    // reset values, then the 8-byte image cycle by cycle
    rst = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_data = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_core_rst", 32'(core_rst), 32'd1);
    check("rst_done_ovf", {30'd0, done, err_overflow}, 32'd0);
    check("rst_wc", word_count, 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 15; i++) begin
      check($sformatf("vec%0d_ctl", i),
            {20'd0, in_ready, mem_we, core_rst, done, word_count[7:0]},
            {20'd0, tbl[i].rdy, tbl[i].we, tbl[i].crst, tbl[i].dn, tbl[i].wc});
      if (tbl[i].we) begin
        check($sformatf("vec%0d_addr", i), mem_addr, tbl[i].addr);
        check($sformatf("vec%0d_wdata", i), mem_wdata, tbl[i].wdata);
      end
      in_valid = tbl[i].v;
      in_data = tbl[i].d;
      in_last = tbl[i].l;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    check("t1_nwrites", 32'(wa.size()), 32'd2);

    // partial final word goes through FLUSH with zero padding
    reset_dut();
    send(8'hEF, 1'b0);
    send(8'hBE, 1'b0);
    send(8'hAD, 1'b0);
    send(8'hDE, 1'b0);
    send(8'h7F, 1'b1);
    check("t2_flush_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("t2_flush_we", 32'(mem_we), 32'd1);
    wait_done(k);
    check("t2_release_lat", 32'(k), 32'd4);
    check_write(0, 32'd0, 32'hDEADBEEF);
    check_write(1, 32'd1, 32'h0000007F);
    check("t2_nwrites", 32'(wa.size()), 32'd2);
    check("t2_wc", word_count, 32'd2);
    check("t2_core_rst", 32'(core_rst), 32'd0);

    // overflow: third word is dropped and the loader halts
    reset_dut();
    for (int i = 0; i < 12; i++) send(8'(i), (i == 11));
    repeat (10) @(negedge clk);
    check("t3_nwrites", 32'(wa.size()), 32'd2);
    check_write(0, 32'd0, 32'h03020100);
    check_write(1, 32'd1, 32'h07060504);
    check("t3_ovf", 32'(err_overflow), 32'd1);
    check("t3_halt", {29'd0, core_rst, done, in_ready}, {29'd0, 1'b1, 1'b0, 1'b0});
    check("t3_wc", word_count, 32'd2);

    // bubbles between bytes
    reset_dut();
    for (int i = 1; i <= 4; i++) begin
      send(8'(i), (i == 4));
      @(negedge clk);
    end
    repeat (8) @(negedge clk);
    check("t4_nwrites", 32'(wa.size()), 32'd1);
    check_write(0, 32'd0, 32'h04030201);
    check("t4_done", 32'(done), 32'd1);

    // asynchronous reset from RUN
    rst = 1'b0;
    #1;
    check("t5_run_rst", {29'd0, core_rst, done, in_ready}, {29'd0, 1'b1, 1'b0, 1'b0});
    check("t5_run_rst_wc", word_count, 32'd0);
    @(negedge clk);

    // reset mid-word discards stale bytes
    reset_dut();
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    rst = 1'b0;
    #1;
    check("t5_mid_rst_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    reset_dut();
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    send(8'hCC, 1'b0);
    send(8'hDD, 1'b1);
    wait_done(k);
    check("t5_nwrites", 32'(wa.size()), 32'd1);
    check_write(0, 32'd0, 32'hDDCCBBAA);
    check("t5_done", 32'(done), 32'd1);

    // single-byte image
    reset_dut();
    send(8'h5A, 1'b1);
    wait_done(k);
    check("t6_nwrites", 32'(wa.size()), 32'd1);
    check_write(0, 32'd0, 32'h0000005A);
    check("t6_wc", word_count, 32'd1);
    check("t6_done", 32'(done), 32'd1);

`ifdef LOADER_CHECKSUM_EN
    for (int r = 0; r < 2; r++) begin
      exp_sum = (r == 0) ? 32'h3 : 32'h4;
      reset_dut();
      send(8'h01, 1'b0);
      send(8'h00, 1'b0);
      send(8'h00, 1'b0);
      send(8'h00, 1'b0);
      send(8'h02, 1'b0);
      send(8'h00, 1'b0);
      send(8'h00, 1'b0);
      send(8'h00, 1'b1);
      repeat (10) @(negedge clk);
      check($sformatf("t7_%0d_sum", r), chk_sum, 32'h3);
      check($sformatf("t7_%0d_err", r), 32'(err_checksum), 32'(r));
      check($sformatf("t7_%0d_state", r), {30'd0, core_rst, done}, (r == 0) ? 32'd1 : 32'd2);
    end
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
